// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the compressed floating-point code
// used by the encoder and the decoder.
package fp_pkg;

  localparam int WIDTH = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  // Largest representable magnitude: full significand shifted by the top exponent.
  localparam int MAX_MAG = ((1 << SIG_W) - 1) << ((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/fp_to_linear_decoder.sv
// Expands a sign/exponent/significand code into a two's-complement linear value
// using one left shift per clock, with a start/busy/done handshake.
module fp_to_linear_decoder
  import fp_pkg::*;
#(
  parameter int WIDTH = fp_pkg::WIDTH,
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int SIG_W = fp_pkg::SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [SIG_W-1:0] sig_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  state_e             state_q;
  logic [WIDTH-1:0]   mag_q;
  logic [EXP_W-1:0]   cnt_q;
  logic               sgn_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   value_q;

  // Conversion FSM; busy, done and value are all registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_q   <= {WIDTH{1'b0}};
      cnt_q   <= {EXP_W{1'b0}};
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mag_q   <= {{(WIDTH-SIG_W){1'b0}}, sig_in};
            cnt_q   <= exp_in;
            sgn_q   <= sign_in;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == {EXP_W{1'b0}}) begin
            state_q <= ST_FINISH;
          end else begin
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q - {{(EXP_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FINISH: begin
          // Negating zero yields zero, so negative zero needs no special case.
          value_q <= sgn_q ? (~mag_q + {{(WIDTH-1){1'b0}}, 1'b1}) : mag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign value = value_q;

endmodule
